mem_wb_stage: RTL and testbench



---
 rtl/mem_wb_stage_pkg.sv | 23 ++
 rtl/mem_wb_stage_if.sv | 28 ++
 rtl/mem_wb_stage_data_mem.sv | 27 ++
 rtl/mem_wb_stage.sv | 69 ++++++
 tb/tb_mem_wb_stage.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/mem_wb_stage_pkg.sv
// Shared pipeline definitions for the memory-access / write-back stage:
// word and register-number widths, byte-offset field and the MEM/WB record.
package mem_wb_stage_pkg;

  localparam int WORD_W = 32;
  localparam int REG_W  = 5;
  localparam int OFS_HI = 1;
  localparam int OFS_LO = 0;

  typedef struct packed {
    logic              regwr;
    logic [REG_W-1:0]  rw;
    logic [WORD_W-1:0] di;
  } wb_t;

  // A memory access is misaligned when any byte-offset bit is set.
  function automatic logic is_misaligned(input logic              memwr,
                                         input logic              memtoreg,
                                         input logic [WORD_W-1:0] addr);
    return (memwr | memtoreg) & (addr[OFS_HI:OFS_LO] != 2'b00);
  endfunction

endpackage

// File: rtl/mem_wb_stage_if.sv
// MEM-stage input bus and MEM/WB output bus of the memory-access stage.
interface mem_wb_stage_if
  import mem_wb_stage_pkg::*;
  ();

  logic              MEM_MemtoReg;
  logic              MEM_MemWr;
  logic              MEM_RegWr;
  logic [REG_W-1:0]  MEM_Rw;
  logic [WORD_W-1:0] MEM_Result;
  logic [WORD_W-1:0] MEM_BusB;
  logic              WB_RegWr;
  logic [REG_W-1:0]  WB_Rw;
  logic [WORD_W-1:0] WB_Di;
  logic              AlignErr;
  logic [WORD_W-1:0] ErrAddr;

  modport master (
    output MEM_MemtoReg, MEM_MemWr, MEM_RegWr, MEM_Rw, MEM_Result, MEM_BusB,
    input  WB_RegWr, WB_Rw, WB_Di, AlignErr, ErrAddr
  );

  modport slave (
    input  MEM_MemtoReg, MEM_MemWr, MEM_RegWr, MEM_Rw, MEM_Result, MEM_BusB,
    output WB_RegWr, WB_Rw, WB_Di, AlignErr, ErrAddr
  );

endinterface

// File: rtl/mem_wb_stage_data_mem.sv
// Word-addressed data memory: synchronous write, asynchronous read, no reset.
module data_mem
  import mem_wb_stage_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              CLK,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] din,
  output logic [WORD_W-1:0] dout
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [WORD_W-1:0] mem_q [DEPTH];

  // Write port
  always_ff @(posedge CLK) begin
    if (we) begin
      mem_q[addr] <= din;
    end
  end

  assign dout = mem_q[addr];

endmodule

// File: rtl/mem_wb_stage.sv
// Memory-access stage: alignment check, data memory access, MEM/WB register
// and sticky first-misaligned-address capture.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic          CLK,
  input  logic          reset,
  mem_wb_stage_if.slave bus
);

  logic              mis_s;
  logic              we_s;
  logic [ADDR_W-1:0] idx_s;
  logic [WORD_W-1:0] rdata_s;

  wb_t               wb_d, wb_q;
  logic              align_err_d, align_err_q;
  logic [WORD_W-1:0] err_addr_d, err_addr_q;

  data_mem #(.ADDR_W(ADDR_W)) u_data_mem (
    .CLK  (CLK),
    .we   (we_s),
    .addr (idx_s),
    .din  (bus.MEM_BusB),
    .dout (rdata_s)
  );

  // Address decode, write gating, MEM/WB next state and error capture
  always_comb begin
    mis_s       = is_misaligned(bus.MEM_MemWr, bus.MEM_MemtoReg, bus.MEM_Result);
    idx_s       = bus.MEM_Result[ADDR_W+1:2];
    // Gating with reset keeps memory untouched on every edge seen during reset.
    we_s        = bus.MEM_MemWr & ~mis_s & ~reset;
    wb_d.regwr  = bus.MEM_RegWr & ~mis_s;
    wb_d.rw     = bus.MEM_Rw;
    wb_d.di     = bus.MEM_MemtoReg ? rdata_s : bus.MEM_Result;
    align_err_d = align_err_q;
    err_addr_d  = err_addr_q;
    if (mis_s && !align_err_q) begin
      align_err_d = 1'b1;
      err_addr_d  = bus.MEM_Result;
    end else begin
      align_err_d = align_err_q;
      err_addr_d  = err_addr_q;
    end
  end

  // MEM/WB pipeline register and sticky error state
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      wb_q        <= '0;
      align_err_q <= 1'b0;
      err_addr_q  <= '0;
    end else begin
      wb_q        <= wb_d;
      align_err_q <= align_err_d;
      err_addr_q  <= err_addr_d;
    end
  end

  assign bus.WB_RegWr = wb_q.regwr;
  assign bus.WB_Rw    = wb_q.rw;
  assign bus.WB_Di    = wb_q.di;
  assign bus.AlignErr = align_err_q;
  assign bus.ErrAddr  = err_addr_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: behavioural memory/pipeline model with
// a per-cycle compare process plus directed vectors with literal expectations.
module tb_mem_wb_stage;

  logic CLK;
  logic reset;
  int   checks;
  int   errors;

  mem_wb_stage_if bus();

  mem_wb_stage #(.ADDR_W(8)) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Behavioural model: 256-word memory with known-content flags.
  logic [31:0] m_mem [256];
  bit          m_known [256];
  logic [7:0]  m_idx;
  logic        m_mis;
  logic        e_regwr, e_ae, e_dv;
  logic [4:0]  e_rw;
  logic [31:0] e_di, e_ea;

  assign m_idx = 8'((bus.MEM_Result / 32'd4) % 32'd256);
  assign m_mis = (bus.MEM_MemWr || bus.MEM_MemtoReg) && ((bus.MEM_Result % 32'd4) != 32'd0);

  always @(posedge CLK or posedge reset) begin
    if (reset) begin
      e_regwr <= 1'b0;
      e_rw    <= 5'd0;
      e_di    <= 32'd0;
      e_dv    <= 1'b1;
      e_ae    <= 1'b0;
      e_ea    <= 32'd0;
    end else begin
      e_rw    <= bus.MEM_Rw;
      e_regwr <= bus.MEM_RegWr && !m_mis;
      if (bus.MEM_MemtoReg) begin
        e_di <= m_mem[m_idx];
        e_dv <= m_known[m_idx];
      end else begin
        e_di <= bus.MEM_Result;
        e_dv <= 1'b1;
      end
      if (m_mis && !e_ae) begin
        e_ae <= 1'b1;
        e_ea <= bus.MEM_Result;
      end
      if (bus.MEM_MemWr && !m_mis) begin
        m_mem[m_idx]   <= bus.MEM_BusB;
        m_known[m_idx] <= 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic ld, input logic wr, input logic rwen,
                       input logic [4:0] rw, input logic [31:0] res, input logic [31:0] busb);
    bus.MEM_MemtoReg = ld;
    bus.MEM_MemWr    = wr;
    bus.MEM_RegWr    = rwen;
    bus.MEM_Rw       = rw;
    bus.MEM_Result   = res;
    bus.MEM_BusB     = busb;
  endtask

  // Present one instruction and return just after the edge that captures it.
  task automatic issue(input logic ld, input logic wr, input logic rwen,
                       input logic [4:0] rw, input logic [31:0] res, input logic [31:0] busb);
    drive(ld, wr, rwen, rw, res, busb);
    @(posedge CLK);
    #2;
  endtask

  task automatic expect_wb(input string name, input logic regwr, input logic [4:0] rw,
                           input logic [31:0] di);
    chk({name, ".regwr"}, {31'd0, bus.WB_RegWr}, {31'd0, regwr});
    chk({name, ".rw"},    {27'd0, bus.WB_Rw},    {27'd0, rw});
    chk({name, ".di"},    bus.WB_Di,             di);
  endtask

  task automatic expect_err(input string name, input logic ae, input logic [31:0] ea);
    chk({name, ".ae"}, {31'd0, bus.AlignErr}, {31'd0, ae});
    chk({name, ".ea"}, bus.ErrAddr,           ea);
  endtask

  task automatic reset_with_store(input int cycles);
    reset = 1'b1;
    for (int c = 0; c < cycles; c++) begin
      drive(1'($urandom), 1'b1, 1'($urandom), 5'($urandom), 32'h0000_0040, $urandom);
      @(posedge CLK);
      #2;
      expect_wb("rst_hold", 1'b0, 5'd0, 32'd0);
      expect_err("rst_hold", 1'b0, 32'd0);
    end
    reset = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);

    fork
      forever begin
        @(negedge CLK);
        chk("model.regwr", {31'd0, bus.WB_RegWr}, {31'd0, e_regwr});
        chk("model.rw",    {27'd0, bus.WB_Rw},    {27'd0, e_rw});
        if (e_dv) chk("model.di", bus.WB_Di, e_di);
        chk("model.ae",    {31'd0, bus.AlignErr}, {31'd0, e_ae});
        chk("model.ea",    bus.ErrAddr,           e_ea);
      end
    join_none

    #1;
    reset_with_store(3);

    issue(1'b0, 1'b1, 1'b0, 5'd0,  32'h0000_0010, 32'hDEAD_BEEF);
    expect_wb("store10", 1'b0, 5'd0, 32'h0000_0010);
    issue(1'b1, 1'b0, 1'b1, 5'd5,  32'h0000_0010, 32'd0);
    expect_wb("load10", 1'b1, 5'd5, 32'hDEAD_BEEF);
    issue(1'b0, 1'b0, 1'b1, 5'd9,  32'h1234_5678, 32'hFFFF_FFFF);
    expect_wb("alu", 1'b1, 5'd9, 32'h1234_5678);
    expect_err("noerr", 1'b0, 32'd0);

    issue(1'b0, 1'b1, 1'b0, 5'd0,  32'h0000_0020, 32'h7777_7777);
    issue(1'b0, 1'b1, 1'b1, 5'd1,  32'h0000_0022, 32'h0000_0001);
    expect_wb("mis_st", 1'b0, 5'd1, 32'h0000_0022);
    expect_err("mis_st", 1'b1, 32'h0000_0022);
    issue(1'b1, 1'b0, 1'b1, 5'd3,  32'h0000_0020, 32'd0);
    expect_wb("word8", 1'b1, 5'd3, 32'h7777_7777);
    issue(1'b1, 1'b0, 1'b1, 5'd4,  32'h0000_0031, 32'd0);
    chk("mis_ld.regwr", {31'd0, bus.WB_RegWr}, 32'd0);
    expect_err("mis_ld", 1'b1, 32'h0000_0022);

    issue(1'b0, 1'b1, 1'b0, 5'd0,  32'h0000_0400, 32'hA5A5_A5A5);
    issue(1'b1, 1'b0, 1'b1, 5'd7,  32'h0000_0000, 32'd0);
    expect_wb("wrap", 1'b1, 5'd7, 32'hA5A5_A5A5);

    issue(1'b1, 1'b1, 1'b1, 5'd6,  32'h0000_0010, 32'hCAFE_F00D);
    expect_wb("both", 1'b1, 5'd6, 32'hDEAD_BEEF);
    issue(1'b1, 1'b0, 1'b1, 5'd0,  32'h0000_0010, 32'd0);
    expect_wb("both_after", 1'b1, 5'd0, 32'hCAFE_F00D);

    issue(1'b0, 1'b1, 1'b0, 5'd0,  32'h0000_0040, 32'h1111_1111);
    reset_with_store(3);
    issue(1'b1, 1'b0, 1'b1, 5'd2,  32'h0000_0040, 32'd0);
    expect_wb("rst_nowrite", 1'b1, 5'd2, 32'h1111_1111);

    issue(1'b0, 1'b0, 1'b1, 5'd10, 32'h0000_0055, 32'd0);
    expect_wb("pre_rst", 1'b1, 5'd10, 32'h0000_0055);
    drive(1'b1, 1'b0, 1'b1, 5'd11, 32'h0000_0010, 32'd0);
    #1;
    reset = 1'b1;
    #1;
    expect_wb("async_rst", 1'b0, 5'd0, 32'd0);
    @(posedge CLK);
    #2;
    reset = 1'b0;
    issue(1'b0, 1'b0, 1'b1, 5'd12, 32'h0000_0ABC, 32'd0);
    expect_wb("post_rst", 1'b1, 5'd12, 32'h0000_0ABC);

    for (int i = 0; i < 24; i++) begin
      logic [31:0] a;
      a = {24'd0, 3'($urandom_range(0, 7)), 5'd0} | 32'($urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : 0);
      case (i % 3)
        0:       issue(1'b0, 1'b1, 1'($urandom), 5'($urandom), a, $urandom);
        1:       issue(1'b1, 1'b0, 1'b1, 5'($urandom), a, $urandom);
        default: issue(1'b0, 1'b0, 1'b1, 5'($urandom), $urandom, $urandom);
      endcase
    end

    @(negedge CLK);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
